// File: rtl/stream_to_memory.sv
// stream_to_memory: collects a stream of words into a frame buffer and
// presents the whole frame on a parallel output once it is full or the
// upstream transfer ends.
module stream_to_memory #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MEMORY_DEPTH = 20
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // upstream (slave) side
  output logic                                   rtr_o,
  input  logic                                   rts_i,
  input  logic                                   eow_i,
  input  logic [DATA_WIDTH-1:0]                  data_i,
  // downstream (master) side
  input  logic                                   rtr_i,
  output logic                                   rts_o,
  output logic                                   eow_o,
  output logic [DATA_WIDTH-1:0]                  data_o [MEMORY_DEPTH-1:0],
  output logic [$clog2(MEMORY_DEPTH+1)-1:0]      count_o
);

  localparam int unsigned CW = $clog2(MEMORY_DEPTH + 1);
  localparam int unsigned WW = $clog2(MEMORY_DEPTH);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  rtr_q, rtr_d;
  logic                  rts_q, rts_d;
  logic                  eow_q, eow_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WW-1:0]         wc_q, wc_d;
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH-1:0];
  logic [DATA_WIDTH-1:0] mem_d [MEMORY_DEPTH-1:0];

  logic                  slv_hs;
  logic                  mst_hs;
  logic                  last_slot;

  assign slv_hs    = rts_i & rtr_q;
  assign mst_hs    = rts_q & rtr_i;
  assign last_slot = (wc_q == WW'(MEMORY_DEPTH - 1));

  // Next-state logic: fill the buffer, close the frame, release it downstream
  always_comb begin
    state_d = state_q;
    rtr_d   = rtr_q;
    rts_d   = rts_q;
    eow_d   = eow_q;
    count_d = count_q;
    wc_d    = wc_q;
    mem_d   = mem_q;

    unique case (state_q)
      ST_FILL: begin
        // rtr rises one clock after reset release and stays high in FILL
        rtr_d = 1'b1;
        if (slv_hs) begin
          mem_d[wc_q] = data_i;
          if (last_slot || eow_i) begin
            state_d = ST_FULL;
            rtr_d   = 1'b0;
            rts_d   = 1'b1;
            eow_d   = eow_i;
            count_d = CW'(wc_q) + CW'(1);
            wc_d    = '0;
          end else begin
            wc_d = wc_q + WW'(1);
          end
        end
      end
      ST_FULL: begin
        rtr_d = 1'b0;
        if (mst_hs) begin
          state_d = ST_FILL;
          rtr_d   = 1'b1;
          rts_d   = 1'b0;
          eow_d   = 1'b0;
          count_d = '0;
          for (int i = 0; i < int'(MEMORY_DEPTH); i++) begin
            mem_d[i] = '0;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and frame registers; reset discards any partial or pending frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      rtr_q   <= 1'b0;
      rts_q   <= 1'b0;
      eow_q   <= 1'b0;
      count_q <= '0;
      wc_q    <= '0;
      for (int i = 0; i < int'(MEMORY_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rtr_q   <= rtr_d;
      rts_q   <= rts_d;
      eow_q   <= eow_d;
      count_q <= count_d;
      wc_q    <= wc_d;
      for (int i = 0; i < int'(MEMORY_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rtr_o   = rtr_q;
  assign rts_o   = rts_q;
  assign eow_o   = eow_q;
  assign count_o = count_q;
  assign data_o  = mem_q;

endmodule
